frame_config_sequencer: RTL and testbench



---
 rtl/frame_config_sequencer_if.sv | 31 +++
 rtl/frame_config_sequencer.sv | 111 +++++++++++
 tb/tb_frame_config_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_config_sequencer_if.sv
// Bundle of the word handshake and the frame data bus between the
// configuration port bridge (master) and the frame config sequencer (slave).
interface frame_config_sequencer_if #(
  parameter int FrameBitsPerRow  = 32,
  parameter int RowSelectWidth   = 5,
  parameter int FrameSelectWidth = 5
);

  logic [FrameBitsPerRow-1:0]  WordData_I;
  logic                        WordValid_I;
  logic                        WordReady_O;
  logic [FrameBitsPerRow-1:0]  FrameData_O;
  logic [RowSelectWidth-1:0]   RowSelect_O;
  logic [FrameSelectWidth-1:0] FrameAddress_O;
  logic                        FrameStrobe_O;
  logic                        Busy_O;
  logic                        Error_O;

  modport master (
    output WordData_I, WordValid_I,
    input  WordReady_O, FrameData_O, RowSelect_O, FrameAddress_O,
           FrameStrobe_O, Busy_O, Error_O
  );

  modport slave (
    input  WordData_I, WordValid_I,
    output WordReady_O, FrameData_O, RowSelect_O, FrameAddress_O,
           FrameStrobe_O, Busy_O, Error_O
  );

endinterface

// File: rtl/frame_config_sequencer.sv
// Frame config sequencer: hunts for the sync word, decodes frame headers and
// writes NumberOfRows data words onto the shared FrameData/RowSelect bus,
// then pulses FrameStrobe with the frame address of the completed frame.
module frame_config_sequencer #(
  parameter int                   FrameBitsPerRow  = 32,
  parameter int                   RowSelectWidth   = 5,
  parameter int                   NumberOfRows     = 10,
  parameter int                   FrameSelectWidth = 5,
  parameter logic [FrameBitsPerRow-1:0] SyncWord   = 32'hFAB0_FAB1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  frame_config_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    ROWS,
    STROBE
  } state_t;

  localparam logic [RowSelectWidth-1:0] LastRow = RowSelectWidth'(NumberOfRows);
  localparam logic [7:0] CmdDesync = 8'h00;
  localparam logic [7:0] CmdWrite  = 8'h01;

  state_t                      state_q;
  logic [RowSelectWidth-1:0]   rowCnt_q;
  logic [FrameBitsPerRow-1:0]  frameData_q;
  logic [RowSelectWidth-1:0]   rowSel_q;
  logic [FrameSelectWidth-1:0] frameAddr_q;
  logic                        strobe_q;
  logic                        busy_q;
  logic                        error_q;

  logic                        accept;
  logic [7:0]                  headerCmd;

  // Ready drops only during the single strobe stall cycle (and in reset)
  assign bus.WordReady_O = !RESET && (state_q != STROBE);
  assign accept          = bus.WordValid_I && bus.WordReady_O;
  assign headerCmd       = bus.WordData_I[FrameBitsPerRow-1:FrameBitsPerRow-8];

  assign bus.FrameData_O    = frameData_q;
  assign bus.RowSelect_O    = rowSel_q;
  assign bus.FrameAddress_O = frameAddr_q;
  assign bus.FrameStrobe_O  = strobe_q;
  assign bus.Busy_O         = busy_q;
  assign bus.Error_O        = error_q;

  // Sequencer FSM; row select and strobe default to idle so they only pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      rowCnt_q    <= '0;
      frameData_q <= '0;
      rowSel_q    <= '0;
      frameAddr_q <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      rowSel_q <= '0;
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && (bus.WordData_I == SyncWord)) begin
            state_q <= HEADER;
            busy_q  <= 1'b1;
          end
        end
        HEADER: begin
          if (accept) begin
            if (headerCmd == CmdWrite) begin
              frameAddr_q <= bus.WordData_I[FrameSelectWidth-1:0];
              rowCnt_q    <= {{(RowSelectWidth-1){1'b0}}, 1'b1};
              state_q     <= ROWS;
            end else if (headerCmd == CmdDesync) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ROWS: begin
          if (accept) begin
            frameData_q <= bus.WordData_I;
            rowSel_q    <= rowCnt_q;
            if (rowCnt_q == LastRow) begin
              state_q <= STROBE;
            end else begin
              rowCnt_q <= rowCnt_q + 1'b1;
            end
          end
        end
        STROBE: begin
          strobe_q <= 1'b1;
          state_q  <= HEADER;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Self-checking bench for frame_config_sequencer: a cycle-accurate vector
// table for one full-rate frame, then scoreboarded sessions covering gaps,
// junk before sync, multi-frame sessions, header errors, reset mid-frame and
// sync-valued row data.
module tb_frame_config_sequencer;

  localparam logic [31:0] Sync = 32'hFAB0_FAB1;

  logic CLK;
  logic RESET;

  frame_config_sequencer_if #(
    .FrameBitsPerRow (32),
    .RowSelectWidth  (5),
    .FrameSelectWidth(5)
  ) bus ();

  frame_config_sequencer #(
    .FrameBitsPerRow (32),
    .RowSelectWidth  (5),
    .NumberOfRows    (10),
    .FrameSelectWidth(5),
    .SyncWord        (Sync)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        valid;
    logic [31:0] word;
    logic        expReady;
    logic [4:0]  expRow;
    logic [31:0] expData;
    logic        expStrobe;
    logic        expBusy;
    logic [4:0]  expAddr;
  } vec_t;

  typedef struct {
    logic [4:0]  row;
    logic [31:0] data;
  } rowExp_t;

  vec_t       vecs[14];
  rowExp_t    rowQ[$];
  logic [4:0] strobeQ[$];
  int         testsRun  = 0;
  int         failures  = 0;
  logic       monEnable = 1'b0;

  // Free-running clock, 10 time units per cycle
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case something stalls beyond every per-word bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word and hold it until the sequencer accepts it
  task automatic applyStimulus(input logic [31:0] w);
    int tries;
    tries = 0;
    @(negedge CLK);
    bus.WordValid_I = 1'b1;
    bus.WordData_I  = w;
    while (!bus.WordReady_O && tries < 20) begin
      @(negedge CLK);
      tries++;
    end
    if (!bus.WordReady_O) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL readyTimeout: word %0h never accepted", w);
    end
    @(posedge CLK);
  endtask

  task automatic idleCycle();
    @(negedge CLK);
    bus.WordValid_I = 1'b0;
    @(posedge CLK);
  endtask

  // Header plus NumberOfRows words; one row may carry a special value
  task automatic sendFrame(input logic [4:0] addr, input logic [31:0] base,
                           input bit gaps, input int specialRow, input logic [31:0] specialWord);
    logic [31:0] w;
    rowExp_t     e;
    applyStimulus(32'h0100_0000 | {27'd0, addr});
    if (gaps) idleCycle();
    for (int k = 1; k <= 10; k++) begin
      w = (k == specialRow) ? specialWord : base + k;
      e.row  = 5'(k);
      e.data = w;
      rowQ.push_back(e);
      applyStimulus(w);
      if (gaps) idleCycle();
    end
    strobeQ.push_back(addr);
  endtask

  task automatic drainCheck(input string tag);
    repeat (4) idleCycle();
    checkOutput({tag, "_rowQEmpty"}, 32'(rowQ.size()), 32'd0);
    checkOutput({tag, "_strobeQEmpty"}, 32'(strobeQ.size()), 32'd0);
  endtask

  // Scoreboard side: every row write and strobe must match the next expectation
  task automatic runMonitor();
    rowExp_t    e;
    logic [4:0] a;
    forever begin
      @(negedge CLK);
      if (monEnable) begin
        if (bus.RowSelect_O != 5'd0) begin
          if (rowQ.size() == 0) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL unexpectedRow: got row %0d data %0h expected none", bus.RowSelect_O, bus.FrameData_O);
          end else begin
            e = rowQ.pop_front();
            checkOutput("rowSel", 32'(bus.RowSelect_O), 32'(e.row));
            checkOutput("rowData", bus.FrameData_O, e.data);
          end
        end
        if (bus.FrameStrobe_O) begin
          if (strobeQ.size() == 0) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL unexpectedStrobe: got strobe addr %0h expected none", bus.FrameAddress_O);
          end else begin
            a = strobeQ.pop_front();
            checkOutput("strobeAddr", 32'(bus.FrameAddress_O), 32'(a));
          end
        end
      end
    end
  endtask

  initial begin
    RESET           = 1'b1;
    bus.WordValid_I = 1'b0;
    bus.WordData_I  = '0;

    // Full-rate frame, expectations are the outputs right after each edge
    vecs[0] = '{1'b1, Sync,          1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0};
    vecs[1] = '{1'b1, 32'h0100_0007, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7};
    for (int k = 1; k <= 10; k++) begin
      vecs[k+1] = '{1'b1, 32'(k), (k == 10) ? 1'b0 : 1'b1, 5'(k), 32'(k), 1'b0, 1'b1, 5'd7};
    end
    vecs[12] = '{1'b0, 32'h0, 1'b1, 5'd0, 32'hA, 1'b1, 1'b1, 5'd7};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 5'd0, 32'hA, 1'b0, 1'b1, 5'd7};

    fork
      runMonitor();
    join_none

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_ready", 32'(bus.WordReady_O), 32'd0);
    checkOutput("rst_row", 32'(bus.RowSelect_O), 32'd0);
    checkOutput("rst_data", bus.FrameData_O, 32'd0);
    checkOutput("rst_addr", 32'(bus.FrameAddress_O), 32'd0);
    checkOutput("rst_strobe", 32'(bus.FrameStrobe_O), 32'd0);
    checkOutput("rst_busy", 32'(bus.Busy_O), 32'd0);
    checkOutput("rst_error", 32'(bus.Error_O), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("post_rst_ready", 32'(bus.WordReady_O), 32'd1);

    // Table-driven full-rate frame
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      bus.WordValid_I = vecs[i].valid;
      bus.WordData_I  = vecs[i].word;
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), 32'(bus.WordReady_O), 32'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d_row", i), 32'(bus.RowSelect_O), 32'(vecs[i].expRow));
      checkOutput($sformatf("vec%0d_data", i), bus.FrameData_O, vecs[i].expData);
      checkOutput($sformatf("vec%0d_strobe", i), 32'(bus.FrameStrobe_O), 32'(vecs[i].expStrobe));
      checkOutput($sformatf("vec%0d_busy", i), 32'(bus.Busy_O), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_addr", i), 32'(bus.FrameAddress_O), 32'(vecs[i].expAddr));
    end
    applyStimulus(32'h0000_0000);
    idleCycle();
    @(negedge CLK);
    checkOutput("t1_busyAfterDesync", 32'(bus.Busy_O), 32'd0);

    monEnable = 1'b1;

    // Same frame with a gap after every word
    $display("[TB] gapped frame");
    applyStimulus(Sync);
    idleCycle();
    sendFrame(5'd7, 32'h0, 1'b1, 0, 32'h0);
    applyStimulus(32'h0000_0000);
    drainCheck("t2");

    // Junk before sync, two back-to-back frames, then desync
    $display("[TB] junk then two frames");
    applyStimulus(32'h1234_5678);
    applyStimulus(32'h0000_0000);
    idleCycle();
    @(negedge CLK);
    checkOutput("t3_busyAfterJunk", 32'(bus.Busy_O), 32'd0);
    applyStimulus(Sync);
    sendFrame(5'd3, 32'h30, 1'b0, 0, 32'h0);
    sendFrame(5'd4, 32'h40, 1'b0, 0, 32'h0);
    @(negedge CLK);
    checkOutput("t3_busyMidSession", 32'(bus.Busy_O), 32'd1);
    applyStimulus(32'h0000_0000);
    idleCycle();
    @(negedge CLK);
    checkOutput("t3_busyAfterDesync", 32'(bus.Busy_O), 32'd0);
    drainCheck("t3");

    // Illegal header sets a sticky error and returns to idle
    $display("[TB] illegal header");
    applyStimulus(Sync);
    applyStimulus(32'h0500_0001);
    idleCycle();
    @(negedge CLK);
    checkOutput("t4_error", 32'(bus.Error_O), 32'd1);
    checkOutput("t4_busy", 32'(bus.Busy_O), 32'd0);
    applyStimulus(32'h0000_0055);
    idleCycle();
    applyStimulus(Sync);
    sendFrame(5'd2, 32'h100, 1'b0, 0, 32'h0);
    applyStimulus(32'h0000_0000);
    drainCheck("t4");
    checkOutput("t4_errorSticky", 32'(bus.Error_O), 32'd1);

    // Reset partway through a frame
    $display("[TB] reset mid-frame");
    applyStimulus(Sync);
    applyStimulus(32'h0100_0009);
    for (int k = 1; k <= 5; k++) begin
      rowQ.push_back('{5'(k), 32'h200 + 32'(k)});
      applyStimulus(32'h200 + 32'(k));
    end
    @(negedge CLK);
    RESET           = 1'b1;
    bus.WordValid_I = 1'b0;
    @(negedge CLK);
    checkOutput("t5_ready", 32'(bus.WordReady_O), 32'd0);
    checkOutput("t5_row", 32'(bus.RowSelect_O), 32'd0);
    checkOutput("t5_data", bus.FrameData_O, 32'd0);
    checkOutput("t5_addr", 32'(bus.FrameAddress_O), 32'd0);
    checkOutput("t5_strobe", 32'(bus.FrameStrobe_O), 32'd0);
    checkOutput("t5_busy", 32'(bus.Busy_O), 32'd0);
    checkOutput("t5_error", 32'(bus.Error_O), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("t5_readyAfter", 32'(bus.WordReady_O), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(32'h300 + 32'(k));
    end
    idleCycle();
    @(negedge CLK);
    checkOutput("t5_busyIgnored", 32'(bus.Busy_O), 32'd0);
    drainCheck("t5");

    // Sync pattern as row data is just data
    $display("[TB] sync word as row data");
    applyStimulus(Sync);
    sendFrame(5'd5, 32'h500, 1'b0, 4, Sync);
    applyStimulus(32'h0000_0000);
    drainCheck("t6");

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
